// File: rtl/memoria_dados_v2_pkg.sv
// Shared types and encodings for the data memory and its load extender.
package memoria_dados_v2_pkg;

  localparam int unsigned XLEN = 32;

  // Access size, matching funct3[1:0] of RV32 loads/stores
  typedef enum logic [1:0] {
    SzByte    = 2'b00,
    SzHalf    = 2'b01,
    SzWord    = 2'b10,
    SzIllegal = 2'b11
  } size_e;

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  // RV32I load/store funct3 values
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  // Decoder helpers: funct3[1:0] is the size, funct3[2] selects zero-extension
  function automatic size_e funct3_size(input logic [2:0] f3);
    return size_e'(f3[1:0]);
  endfunction

  function automatic logic funct3_unsigned(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/memoria_dados_v2_if.sv
// Request/response bundle between the datapath and the data memory.
interface memoria_dados_v2_if
  import memoria_dados_v2_pkg::*;
();
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/memoria_dados_v2_extensor_carga.sv
// Load lane select plus sign/zero extension; purely combinational.
module extensor_carga
  import memoria_dados_v2_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      lane,
  input  size_e           size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half and extend it to 32 bits
  always_comb begin
    byte_sel = word[8*lane +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    data     = '0;
    case (size)
      SzByte:  data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SzHalf:  data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SzWord:  data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/memoria_dados_v2.sv
// Synchronous byte-addressed data memory with registered responses and a
// post-reset zero-fill sequencer.
module memoria_dados_v2
  import memoria_dados_v2_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  memoria_dados_v2_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              rsp_err_q;
  logic [XLEN-1:0]   mem [DEPTH];

  logic              accept;
  logic              err;
  size_e             size;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        be;
  logic [XLEN-1:0]   wdata_rep;
  logic [XLEN-1:0]   rd_word;
  logic [XLEN-1:0]   load_data;

  // Ready only in RUN and never while reset is asserted
  assign bus.req_ready = rst_n && (state_q == StRun);
  assign bus.busy      = !bus.req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept   = bus.req_valid && bus.req_ready;
  assign size     = size_e'(bus.req_size);
  assign lane     = bus.req_addr[1:0];
  assign word_idx = bus.req_addr[ADDR_W+1:2];
  assign rd_word  = mem[word_idx];

  // Illegal size, misalignment, or address beyond the array
  always_comb begin
    err = 1'b0;
    case (size)
      SzByte:  err = 1'b0;
      SzHalf:  err = lane[0];
      SzWord:  err = |lane;
      default: err = 1'b1;
    endcase
    if ((bus.req_addr >> (ADDR_W + 2)) != '0) err = 1'b1;
  end

  // Byte-enable mask and lane-replicated store data
  always_comb begin
    be        = 4'b0000;
    wdata_rep = bus.req_wdata;
    case (size)
      SzByte: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      SzHalf: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      SzWord:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(accept && bus.req_we) || err) be = 4'b0000;
  end

  extensor_carga u_extensor_carga (
    .word        (rd_word),
    .lane        (lane),
    .size        (size),
    .is_unsigned (bus.req_unsigned),
    .data        (load_data)
  );

  // Array update: zero-fill during CLEAR, byte-lane stores in RUN; reset leaves it alone
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == StClear) && CLEAR_ON_RESET) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Clear/run FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StClear;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && err;
      rsp_rdata_q <= (accept && !err && !bus.req_we) ? load_data : '0;
      case (state_q)
        StClear: begin
          if (CLEAR_ON_RESET) cnt_q <= cnt_q + ADDR_W'(1);
          if (!CLEAR_ON_RESET || (&cnt_q)) state_q <= StRun;
        end
        StRun:   state_q <= StRun;
        default: state_q <= StClear;
      endcase
    end
  end

endmodule
